// File: rtl/ma_channel_scheduler.sv
// ma_channel_scheduler: round-robin shared moving-average engine with per-channel history and running sum
module ma_channel_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int WINDOW_LOG2 = 3,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int ACC_W      = DATA_W + WINDOW_LOG2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic [DATA_W-1:0]        out_avg,
    output logic                     out_warm
);
    localparam int WINDOW = 1 << WINDOW_LOG2;
    localparam int CLR_W  = CH_W + WINDOW_LOG2;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(NUM_CH * WINDOW - 1);
    localparam logic [WINDOW_LOG2:0] FULL = (WINDOW_LOG2 + 1)'(WINDOW);

    typedef enum logic [2:0] {CLEAR, IDLE, READ, UPDATE, OUTPUT} state_t;

    state_t                 state;
    logic [CH_W-1:0]        rr;
    logic [CH_W-1:0]        cur_ch;
    logic [CH_W-1:0]        gnt;
    logic                   found;
    logic                   take;
    logic                   flush_pend;
    logic [DATA_W-1:0]      cur_data;
    logic [DATA_W-1:0]      oldest;
    logic [CLR_W-1:0]       clr_idx;
    logic [ACC_W-1:0]       new_sum;
    logic [WINDOW_LOG2:0]   new_cnt;
    logic [DATA_W-1:0]      hist [NUM_CH][WINDOW];
    logic [ACC_W-1:0]       sum  [NUM_CH];
    logic [WINDOW_LOG2:0]   cnt  [NUM_CH];
    logic [WINDOW_LOG2-1:0] wptr [NUM_CH];

    // Round-robin pick: scan from farthest to nearest after rr so the nearest valid channel wins
    always_comb begin
        gnt   = rr;
        found = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (req_valid[(int'(rr) + k) % NUM_CH]) begin
                gnt   = CH_W'((int'(rr) + k) % NUM_CH);
                found = 1'b1;
            end
        end
    end

    // Accept only in IDLE with no flush outstanding; a coincident flush beats a grant
    always_comb begin
        take      = state == IDLE && !flush && !flush_pend && found;
        req_ready = take ? NUM_CH'(1) << gnt : '0;
        new_sum   = sum[cur_ch] + ACC_W'(cur_data) - ACC_W'(oldest);
        new_cnt   = cnt[cur_ch] == FULL ? cnt[cur_ch] : cnt[cur_ch] + 1'b1;
    end

    // Control FSM, per-channel sums/counters/pointers and registered result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            rr         <= CH_W'(NUM_CH - 1);
            clr_idx    <= '0;
            flush_pend <= 1'b0;
            cur_ch     <= '0;
            cur_data   <= '0;
            oldest     <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_avg    <= '0;
            out_warm   <= 1'b0;
        end else begin
            flush_pend <= flush_pend | flush;
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        sum[i]  <= '0;
                        cnt[i]  <= '0;
                        wptr[i] <= '0;
                    end
                    if (clr_idx == CLR_LAST) state <= IDLE;
                end
                IDLE: begin
                    if (flush || flush_pend) begin
                        state      <= CLEAR;
                        clr_idx    <= '0;
                        flush_pend <= 1'b0;
                    end else if (found) begin
                        cur_ch   <= gnt;
                        cur_data <= req_data[gnt*DATA_W +: DATA_W];
                        rr       <= gnt;
                        state    <= READ;
                    end
                end
                READ: begin
                    oldest <= hist[cur_ch][wptr[cur_ch]];
                    state  <= UPDATE;
                end
                UPDATE: begin
                    sum[cur_ch]  <= new_sum;
                    wptr[cur_ch] <= wptr[cur_ch] + 1'b1;
                    cnt[cur_ch]  <= new_cnt;
                    out_ch       <= cur_ch;
                    out_avg      <= new_sum[WINDOW_LOG2 +: DATA_W];
                    out_warm     <= new_cnt == FULL;
                    out_valid    <= 1'b1;
                    state        <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // History storage: wiped one entry per cycle during CLEAR, written with the new sample in UPDATE
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            hist[clr_idx[WINDOW_LOG2 +: CH_W]][clr_idx[WINDOW_LOG2-1:0]] <= '0;
        else if (state == UPDATE)
            hist[cur_ch][wptr[cur_ch]] <= cur_data;
    end
endmodule

// File: tb/tb_ma_channel_scheduler.sv
// tb_ma_channel_scheduler: scoreboard bench for the shared moving-average scheduler
module tb_ma_channel_scheduler;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [1:0]   out_ch;
    logic [31:0]  out_avg;
    logic         out_warm;

    ma_channel_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_avg(out_avg), .out_warm(out_warm)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; logic [31:0] avg; logic warm; int t;} exp_t;
    exp_t q[$];
    exp_t e;
    int acc_t[$];
    int acc_ch[$];
    int checks = 0, fails = 0, cyc = 0, n_acc = 0, hs_t = 0, rr_m = 3, g, s;
    bit ov_seen = 0;
    logic [31:0] mh [4][8];
    int mp [4];
    int mn [4];
    logic [34:0] msum;
    logic [31:0] last_avg = '0;
    logic last_warm = 1'b0;
    logic [1:0] snap_ch;
    logic [31:0] snap_avg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int nxt(input int rr, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) if (v[(rr + k) % 4]) return (rr + k) % 4;
        return -1;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 8; p++) mh[c][p] = '0;
            mp[c] = 0;
            mn[c] = 0;
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: predicts each grant and result at accept time, checks results at handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 0) begin
                g = nxt(rr_m, req_valid);
                check("grant", req_ready, g < 0 ? 0 : (1 << g));
                if (g >= 0) begin
                    rr_m = g;
                    mh[g][mp[g]] = req_data[g*32 +: 32];
                    mp[g] = (mp[g] + 1) % 8;
                    if (mn[g] < 8) mn[g]++;
                    msum = '0;
                    for (int p = 0; p < 8; p++) msum += 35'(mh[g][p]);
                    e.ch = g; e.avg = msum[34:3]; e.warm = mn[g] == 8; e.t = cyc;
                    q.push_back(e);
                    acc_t.push_back(cyc);
                    acc_ch.push_back(g);
                    n_acc++;
                end
            end
            if (out_valid) begin
                if (!ov_seen) begin
                    ov_seen = 1;
                    check("q_nonempty", q.size() != 0, 1);
                    if (q.size() != 0) check("latency", cyc - q[0].t, 3);
                end
                if (out_ready) begin
                    ov_seen = 0;
                    hs_t = cyc;
                    last_avg = out_avg;
                    last_warm = out_warm;
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("out_ch", out_ch, e.ch);
                        check("out_avg", out_avg, e.avg);
                        check("out_warm", out_warm, e.warm);
                    end
                end
            end
        end
    end

    task automatic wait_acc(input int n);
        int k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (n_acc < n && k < 300);
        check("accept_seen", n_acc >= n, 1);
        #1;
    endtask

    task automatic send(input int ch, input logic [31:0] d);
        req_data[ch*32 +: 32] = d;
        req_valid = 4'(1 << ch);
        wait_acc(n_acc + 1);
        req_valid = '0;
    endtask

    task automatic drain();
        int k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (q.size() != 0 && k < 300);
        check("drained", q.size(), 0);
        #1;
    endtask

    task automatic wait_out();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 300);
        check("out_valid_seen", out_valid, 1);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        req_data = {4{32'd8}};
        req_valid = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_avg", out_avg, 0);
        check("rst_out_warm", out_warm, 0);
        check("rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        s = 0;
        while (s < 100) begin
            @(negedge clk);
            if (req_ready != 0) break;
            s++;
        end
        check("clear_len", s, 32);
        check("first_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid = '0;

        repeat (7) send(0, 32'd8);
        drain();
        check("ch0_avg8", last_avg, 8);
        check("ch0_warm8", last_warm, 1);
        send(0, 32'd16);
        drain();
        check("ch0_avg9", last_avg, 9);

        send(3, 32'd5);
        drain();
        req_data = {32'd40, 32'd30, 32'd20, 32'd10};
        s = n_acc;
        req_valid = 4'hF;
        wait_acc(s + 6);
        req_valid = '0;
        for (int i = 0; i < 6; i++) check("rr_order", acc_ch[s + i], i % 4);
        for (int i = 1; i < 6; i++) check("rr_spacing", acc_t[s + i] - acc_t[s + i - 1], 4);
        drain();

        out_ready = 1'b0;
        send(0, 32'd8);
        req_data[95:64] = 32'd7;
        req_valid = 4'b0100;
        wait_out();
        snap_ch = out_ch;
        snap_avg = out_avg;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_ch", out_ch, snap_ch);
            check("stall_avg", out_avg, snap_avg);
            check("stall_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        s = n_acc;
        wait_acc(s + 1);
        req_valid = '0;
        check("release_gap", acc_t[acc_t.size() - 1] - hs_t, 1);
        drain();

        repeat (7) send(1, 32'd8);
        drain();
        out_ready = 1'b0;
        send(1, 32'd8);
        wait_out();
        check("ch1_avg_pre", out_avg, 8);
        check("ch1_warm_pre", out_warm, 1);
        @(posedge clk);
        #1 flush = 1'b1;
        model_clear();
        @(posedge clk);
        #1 flush = 1'b0;
        out_ready = 1'b1;
        req_data[63:32] = 32'd80;
        req_valid = 4'b0010;
        s = n_acc;
        wait_acc(s + 1);
        req_valid = '0;
        check("flush_gap", acc_t[acc_t.size() - 1] - hs_t, 34);
        drain();
        check("ch1_avg_post", last_avg, 10);
        check("ch1_warm_post", last_warm, 0);

        repeat (8) send(2, 32'hFFFFFFFF);
        drain();
        check("ch2_avg_max", last_avg, 32'hFFFFFFFF);
        check("ch2_warm_max", last_warm, 1);
        send(2, 32'd0);
        drain();
        check("ch2_avg_drop", last_avg, 32'hDFFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
